// File: rtl/signed_add_sat_pipe.sv
// Multi-lane two-stage pipelined signed adder with saturation and optional
// per-lane accumulation; stage 1 adds/saturates/updates acc, stage 2 drives outputs.
module signed_add_sat_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     mode,
  input  logic                     acc_clear,
  input  logic [LANES*WIDTH-1:0]   dataa,
  input  logic [LANES*WIDTH-1:0]   datab,
  output logic                     out_valid,
  output logic [LANES*WIDTH-1:0]   result,
  output logic [LANES-1:0]         overflow
);

  localparam int unsigned SW = WIDTH + 2;

  logic [LANES*WIDTH-1:0] acc;
  logic [LANES*WIDTH-1:0] sat_sum;
  logic [LANES-1:0]       sat_flag;
  logic                   s1_valid;
  logic [LANES*WIDTH-1:0] s1_sum;
  logic [LANES-1:0]       s1_ovf;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [SW-1:0]    s;
    logic [2:0]       top;
    logic             clamp;
    logic [WIDTH-1:0] val;

    assign a = dataa[g*WIDTH +: WIDTH];
    assign b = datab[g*WIDTH +: WIDTH];
    // acc_clear with an accumulate beat makes that beat start from zero
    assign c = (mode && !acc_clear) ? acc[g*WIDTH +: WIDTH] : '0;
    assign s = {{2{a[WIDTH-1]}}, a} + {{2{b[WIDTH-1]}}, b} + {{2{c[WIDTH-1]}}, c};
    assign top = s[SW-1:WIDTH-1];
    assign clamp = (top != 3'b000) && (top != 3'b111);

    always_comb begin
      val = s[WIDTH-1:0];
      if (clamp) begin
        if (s[SW-1]) val = {1'b1, {(WIDTH-1){1'b0}}};
        else         val = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end

    assign sat_sum[g*WIDTH +: WIDTH] = val;
    assign sat_flag[g] = clamp;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_ovf    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum <= sat_sum;
        s1_ovf <= sat_flag;
      end
      if (in_valid && mode) acc <= sat_sum;
      else if (acc_clear)   acc <= '0;

      out_valid <= s1_valid;
      if (s1_valid) begin
        result   <= s1_sum;
        overflow <= s1_ovf;
      end
    end
  end

endmodule

// File: tb/tb_signed_add_sat_pipe.sv
// Bench for signed_add_sat_pipe: directed and random beats checked against a
// queue-based arithmetic reference model with a two-cycle output schedule.
module tb_signed_add_sat_pipe;

  localparam int unsigned W = 32;
  localparam int unsigned L = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           mode = 1'b0;
  logic           acc_clear = 1'b0;
  logic [L*W-1:0] dataa = '0;
  logic [L*W-1:0] datab = '0;
  logic           out_valid;
  logic [L*W-1:0] result;
  logic [L-1:0]   overflow;

  signed_add_sat_pipe #(.WIDTH(W), .LANES(L)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .mode(mode),
    .acc_clear(acc_clear), .dataa(dataa), .datab(datab),
    .out_valid(out_valid), .result(result), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned    due;
    logic [L*W-1:0] res;
    logic [L-1:0]   ovf;
  } exp_t;

  exp_t        q[$];
  longint      macc[L];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic longint lane_of(input logic [L*W-1:0] v, input int unsigned i);
    logic [W-1:0] t;
    t = v[i*W +: W];
    return longint'($signed(t));
  endfunction

  // Reference model: plain integer arithmetic on each accepted beat
  task automatic model_edge();
    exp_t   e;
    longint s, r;
    logic [63:0] t;
    e.due = cyc + 1;
    e.res = '0;
    e.ovf = '0;
    for (int unsigned i = 0; i < L; i++) begin
      s = lane_of(dataa, i) + lane_of(datab, i);
      if (mode && !acc_clear) s = s + macc[i];
      r = (s > MAXV) ? MAXV : (s < MINV) ? MINV : s;
      t = r;
      e.res[i*W +: W] = t[W-1:0];
      e.ovf[i] = (s > MAXV) || (s < MINV);
      if (in_valid && mode) macc[i] = r;
      else if (acc_clear) macc[i] = 0;
    end
    if (in_valid) q.push_back(e);
  endtask

  task automatic check_out();
    if (q.size() > 0 && q[0].due == cyc) begin
      checks++;
      assert (out_valid === 1'b1) else begin
        errors++; $error("FAIL out_valid cyc=%0d observed=%b expected=1", cyc, out_valid);
      end
      checks++;
      assert (result === q[0].res) else begin
        errors++; $error("FAIL result cyc=%0d observed=%h expected=%h", cyc, result, q[0].res);
      end
      checks++;
      assert (overflow === q[0].ovf) else begin
        errors++; $error("FAIL overflow cyc=%0d observed=%b expected=%b", cyc, overflow, q[0].ovf);
      end
      void'(q.pop_front());
    end else begin
      checks++;
      assert (out_valid === 1'b0) else begin
        errors++; $error("FAIL idle_valid cyc=%0d observed=%b expected=0", cyc, out_valid);
      end
    end
  endtask

  task automatic beat(input logic v, input logic m, input logic clr,
                      input logic [L*W-1:0] a, input logic [L*W-1:0] b);
    in_valid = v; mode = m; acc_clear = clr; dataa = a; datab = b;
    @(posedge clock);
    cyc++;
    if (!reset) model_edge();
    @(negedge clock);
    in_valid = 1'b0; mode = 1'b0; acc_clear = 1'b0;
    check_out();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) beat(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7fffffff - $urandom_range(0, 3);
      1: return 32'h80000000 + $urandom_range(0, 3);
      2: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [L*W-1:0] rvec();
    logic [L*W-1:0] v;
    for (int unsigned i = 0; i < L; i++) v[i*W +: W] = pick();
    return v;
  endfunction

  logic [L*W-1:0] va, vb;
  logic [W-1:0]   lane0;

  initial begin
    for (int i = 0; i < L; i++) macc[i] = 0;
    repeat (2) @(negedge clock);
    checks++;
    assert (out_valid === 1'b0 && result === '0 && overflow === '0) else begin
      errors++; $error("FAIL reset_state observed=%b/%h/%b expected=0/0/0", out_valid, result, overflow);
    end
    reset = 1'b0;
    idle(1);

    // -1 + -1
    va = '0; vb = '0;
    va[31:0] = 32'hffffffff; vb[31:0] = 32'hffffffff;
    beat(1'b1, 1'b0, 1'b0, va, vb);
    idle(3);
    lane0 = result[31:0];
    checks++;
    assert (lane0 === 32'hfffffffe && overflow[0] === 1'b0) else begin
      errors++; $error("FAIL neg_add observed=%h/%b expected=fffffffe/0", lane0, overflow[0]);
    end

    // Positive and negative clamp, plus a non-clamping lane
    va = '0; vb = '0;
    va[31:0] = 32'h7fffffff; vb[31:0] = 32'h00000001;
    va[63:32] = 32'h80000000; vb[63:32] = 32'hffffffff;
    va[95:64] = 32'hffffffbe; vb[95:64] = 32'h00000025;
    beat(1'b1, 1'b0, 1'b0, va, vb);
    idle(2);
    checks++;
    assert (result[95:0] === 96'hffffffe3_80000000_7fffffff && overflow === 4'b0011) else begin
      errors++; $error("FAIL sat_lanes observed=%h/%b expected=ffffffe380000000_7fffffff/0011", result[95:0], overflow);
    end

    // Accumulate with clear on first beat
    va = '0; vb = '0; va[31:0] = 32'h30; vb[31:0] = 32'h444;
    beat(1'b1, 1'b1, 1'b1, va, vb);
    va[31:0] = 32'h10; vb[31:0] = 32'h0;
    beat(1'b1, 1'b1, 1'b0, va, vb);
    va[31:0] = 32'hfffffb00;
    beat(1'b1, 1'b1, 1'b0, va, vb);
    idle(2);
    lane0 = result[31:0];
    checks++;
    assert (lane0 === 32'hffffff84) else begin
      errors++; $error("FAIL acc_seq observed=%h expected=ffffff84", lane0);
    end

    // Clear alone, accumulate to clamp, interleaved add, then step back down
    beat(1'b0, 1'b0, 1'b1, '0, '0);
    va = '0; vb = '0; va[31:0] = 32'h40000000; vb[31:0] = 32'h40000000;
    beat(1'b1, 1'b1, 1'b0, va, vb);
    beat(1'b1, 1'b1, 1'b0, va, vb);
    beat(1'b1, 1'b0, 1'b0, rvec(), rvec());
    va[31:0] = 32'h80000000; vb[31:0] = 32'h0;
    beat(1'b1, 1'b1, 1'b0, va, vb);
    idle(2);
    lane0 = result[31:0];
    checks++;
    assert (lane0 === 32'hffffffff && overflow[0] === 1'b0) else begin
      errors++; $error("FAIL acc_recover observed=%h/%b expected=ffffffff/0", lane0, overflow[0]);
    end

    // Back-to-back add beats
    for (int k = 0; k < 8; k++) beat(1'b1, 1'b0, 1'b0, rvec(), rvec());
    idle(2);

    // Random mix of valid, mode and clear
    for (int k = 0; k < 300; k++)
      beat(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), rvec(), rvec());
    idle(2);

    // Reset with two beats in flight
    beat(1'b1, 1'b1, 1'b0, rvec(), rvec());
    beat(1'b1, 1'b1, 1'b0, rvec(), rvec());
    reset = 1'b1;
    #1;
    checks++;
    assert (out_valid === 1'b0 && result === '0 && overflow === '0) else begin
      errors++; $error("FAIL async_reset observed=%b/%h/%b expected=0/0/0", out_valid, result, overflow);
    end
    q.delete();
    for (int i = 0; i < L; i++) macc[i] = 0;
    idle(2);
    reset = 1'b0;
    idle(2);
    va = '0; vb = '0; va[31:0] = 32'd5;
    beat(1'b1, 1'b1, 1'b0, va, vb);
    idle(2);
    lane0 = result[31:0];
    checks++;
    assert (lane0 === 32'd5) else begin
      errors++; $error("FAIL post_reset_acc observed=%h expected=00000005", lane0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
